// File: rtl/dcache_port_arbiter.sv
// Two-port arbiter for the single data-memory port: grants, renames ld/st ids to memory tags, routes responses back.
// Optional build macro ARB_FIXED_PRIO_EN: port A always wins contention (no round-robin pointer).
module dcache_port_arbiter #(
    parameter int unsigned NUM_TAGS = 16,
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req_a_valid,
    input  logic [ADDR_W-1:0] req_a_addr,
    input  logic [DATA_W-1:0] req_a_data,
    input  logic              req_a_rw,
    input  logic [3:0]        req_a_id,
    output logic              gnt_a,

    input  logic              req_b_valid,
    input  logic [ADDR_W-1:0] req_b_addr,
    input  logic [DATA_W-1:0] req_b_data,
    input  logic              req_b_rw,
    input  logic [3:0]        req_b_id,
    output logic              gnt_b,

    output logic [ADDR_W-1:0] mem_addr_out,
    output logic [DATA_W-1:0] mem_data_out,
    output logic              mem_rw_out,
    output logic [3:0]        mem_id_out,
    output logic              mem_valid_out,
    input  logic [DATA_W-1:0] mem_data_in,
    input  logic [3:0]        mem_id_in,
    input  logic              mem_ready_in,
    input  logic              mem_stall_in,

    output logic              rsp_a_valid,
    output logic              rsp_b_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic [3:0]        rsp_id,
    output logic [4:0]        outstanding,
    output logic              tag_err
);

    localparam int unsigned TAG_W = 4;
    localparam int unsigned TBL_N = 16;
    localparam int unsigned CNT_W = 5;

    typedef struct packed {
        logic             src;
        logic [TAG_W-1:0] orig_id;
    } tag_meta_t;

    logic [TBL_N-1:0] busy;
    tag_meta_t        meta [TBL_N];

    logic             any_free;
    logic [TAG_W-1:0] alloc_tag;
    logic             can_grant;
    logic             granted;
    logic             rsp_hit;
    logic             rsp_unknown;
    tag_meta_t        hit_meta;
    tag_meta_t        new_meta;

    // Lowest-index free tag, judged on the registered busy vector
    always_comb begin
        any_free  = 1'b0;
        alloc_tag = '0;
        for (int unsigned i = 0; i < NUM_TAGS; i++) begin
            if (!busy[i] && !any_free) begin
                any_free  = 1'b1;
                alloc_tag = TAG_W'(i);
            end
        end
    end

    assign can_grant = rst && !mem_stall_in && any_free;

`ifdef ARB_FIXED_PRIO_EN
    assign gnt_a = can_grant && req_a_valid;
    assign gnt_b = can_grant && req_b_valid && !req_a_valid;
`else
    logic rr_ptr;

    assign gnt_a = can_grant && req_a_valid && (!req_b_valid || !rr_ptr);
    assign gnt_b = can_grant && req_b_valid && (!req_a_valid || rr_ptr);

    // Pointer moves to the loser only when both ports contended and one was granted
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr <= 1'b0;
        end else if (can_grant && req_a_valid && req_b_valid) begin
            rr_ptr <= gnt_a;
        end
    end
`endif

    assign granted     = gnt_a || gnt_b;
    assign rsp_hit     = mem_ready_in && busy[mem_id_in];
    assign rsp_unknown = mem_ready_in && !busy[mem_id_in];
    assign hit_meta    = meta[mem_id_in];
    assign new_meta    = gnt_b ? tag_meta_t'{src: 1'b1, orig_id: req_b_id}
                               : tag_meta_t'{src: 1'b0, orig_id: req_a_id};

    // Tag table; the freed tag was busy this cycle so it never collides with alloc_tag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy <= '0;
            for (int unsigned i = 0; i < TBL_N; i++) begin
                meta[i] <= '0;
            end
        end else begin
            if (rsp_hit) begin
                busy[mem_id_in] <= 1'b0;
            end
            if (granted) begin
                busy[alloc_tag] <= 1'b1;
                meta[alloc_tag] <= new_meta;
            end
        end
    end

    // Memory issue register: one-cycle latency, payload holds when idle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_valid_out <= 1'b0;
            mem_addr_out  <= '0;
            mem_data_out  <= '0;
            mem_rw_out    <= 1'b0;
            mem_id_out    <= '0;
        end else begin
            mem_valid_out <= granted;
            if (granted) begin
                mem_addr_out <= gnt_b ? req_b_addr : req_a_addr;
                mem_data_out <= gnt_b ? req_b_data : req_a_data;
                mem_rw_out   <= gnt_b ? req_b_rw   : req_a_rw;
                mem_id_out   <= alloc_tag;
            end
        end
    end

    // Response return path with original id restored
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_a_valid <= 1'b0;
            rsp_b_valid <= 1'b0;
            rsp_data    <= '0;
            rsp_id      <= '0;
        end else begin
            rsp_a_valid <= rsp_hit && !hit_meta.src;
            rsp_b_valid <= rsp_hit && hit_meta.src;
            if (rsp_hit) begin
                rsp_data <= mem_data_in;
                rsp_id   <= hit_meta.orig_id;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            outstanding <= '0;
            tag_err     <= 1'b0;
        end else begin
            outstanding <= outstanding + CNT_W'(granted) - CNT_W'(rsp_hit);
            tag_err     <= tag_err || rsp_unknown;
        end
    end

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Directed bench for dcache_port_arbiter with a tag-table scoreboard model checked every cycle.
module tb_dcache_port_arbiter;

    localparam int unsigned NT = 16;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req_a_valid = 1'b0, req_b_valid = 1'b0;
    logic [AW-1:0] req_a_addr = '0, req_b_addr = '0;
    logic [DW-1:0] req_a_data = '0, req_b_data = '0;
    logic          req_a_rw = 1'b0, req_b_rw = 1'b0;
    logic [3:0]    req_a_id = '0, req_b_id = '0;
    logic          gnt_a, gnt_b;
    logic [AW-1:0] mem_addr_out;
    logic [DW-1:0] mem_data_out;
    logic          mem_rw_out;
    logic [3:0]    mem_id_out;
    logic          mem_valid_out;
    logic [DW-1:0] mem_data_in = '0;
    logic [3:0]    mem_id_in = '0;
    logic          mem_ready_in = 1'b0;
    logic          mem_stall_in = 1'b0;
    logic          rsp_a_valid, rsp_b_valid;
    logic [DW-1:0] rsp_data;
    logic [3:0]    rsp_id;
    logic [4:0]    outstanding;
    logic          tag_err;

    dcache_port_arbiter #(.NUM_TAGS(NT), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .req_a_valid(req_a_valid), .req_a_addr(req_a_addr), .req_a_data(req_a_data),
        .req_a_rw(req_a_rw), .req_a_id(req_a_id), .gnt_a(gnt_a),
        .req_b_valid(req_b_valid), .req_b_addr(req_b_addr), .req_b_data(req_b_data),
        .req_b_rw(req_b_rw), .req_b_id(req_b_id), .gnt_b(gnt_b),
        .mem_addr_out(mem_addr_out), .mem_data_out(mem_data_out), .mem_rw_out(mem_rw_out),
        .mem_id_out(mem_id_out), .mem_valid_out(mem_valid_out),
        .mem_data_in(mem_data_in), .mem_id_in(mem_id_in), .mem_ready_in(mem_ready_in),
        .mem_stall_in(mem_stall_in),
        .rsp_a_valid(rsp_a_valid), .rsp_b_valid(rsp_b_valid), .rsp_data(rsp_data),
        .rsp_id(rsp_id), .outstanding(outstanding), .tag_err(tag_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: set of in-flight tags with owner and id, plus expected output registers
    bit          m_busy [NT];
    bit          m_src  [NT];
    bit [3:0]    m_oid  [NT];
    bit          m_favour_b;
    bit          m_err;
    bit          e_mem_valid, e_mem_rw, e_rsp_a, e_rsp_b;
    bit [AW-1:0] e_mem_addr;
    bit [DW-1:0] e_mem_data, e_rsp_data;
    bit [3:0]    e_mem_id, e_rsp_id;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_count();
        int c = 0;
        for (int i = 0; i < NT; i++) c += int'(m_busy[i]);
        return c;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NT; i++) begin
            m_busy[i] = 0; m_src[i] = 0; m_oid[i] = '0;
        end
        m_favour_b = 0; m_err = 0;
        e_mem_valid = 0; e_mem_rw = 0; e_rsp_a = 0; e_rsp_b = 0;
        e_mem_addr = '0; e_mem_data = '0; e_rsp_data = '0; e_mem_id = '0; e_rsp_id = '0;
    endtask

    task automatic check_regs(input string tag);
        chk({tag, ".mem_valid"}, 64'(mem_valid_out), 64'(e_mem_valid));
        chk({tag, ".mem_addr"},  64'(mem_addr_out),  64'(e_mem_addr));
        chk({tag, ".mem_data"},  64'(mem_data_out),  64'(e_mem_data));
        chk({tag, ".mem_rw"},    64'(mem_rw_out),    64'(e_mem_rw));
        chk({tag, ".mem_id"},    64'(mem_id_out),    64'(e_mem_id));
        chk({tag, ".rsp_a"},     64'(rsp_a_valid),   64'(e_rsp_a));
        chk({tag, ".rsp_b"},     64'(rsp_b_valid),   64'(e_rsp_b));
        chk({tag, ".rsp_data"},  64'(rsp_data),      64'(e_rsp_data));
        chk({tag, ".rsp_id"},    64'(rsp_id),        64'(e_rsp_id));
        chk({tag, ".outst"},     64'(outstanding),   64'(model_count()));
        chk({tag, ".tag_err"},   64'(tag_err),       64'(m_err));
    endtask

    // One clock: inputs already driven; check grants, advance model, check registered outputs
    task automatic cycle(output bit ga, output bit gb);
        int  tag = 0;
        bit  free = 0;
        #1;
        for (int i = NT - 1; i >= 0; i--) begin
            if (!m_busy[i]) begin free = 1; tag = i; end
        end
        ga = 0; gb = 0;
        if (!mem_stall_in && free) begin
            if (req_a_valid && req_b_valid) begin
`ifdef ARB_FIXED_PRIO_EN
                ga = 1;
`else
                if (m_favour_b) gb = 1; else ga = 1;
                m_favour_b = ga;
`endif
            end else if (req_a_valid) begin
                ga = 1;
            end else if (req_b_valid) begin
                gb = 1;
            end
        end
        chk("gnt_a", 64'(gnt_a), 64'(ga));
        chk("gnt_b", 64'(gnt_b), 64'(gb));
        e_rsp_a = 0; e_rsp_b = 0;
        if (mem_ready_in) begin
            if (m_busy[mem_id_in]) begin
                if (m_src[mem_id_in]) e_rsp_b = 1; else e_rsp_a = 1;
                e_rsp_data = mem_data_in;
                e_rsp_id   = m_oid[mem_id_in];
                m_busy[mem_id_in] = 0;
            end else begin
                m_err = 1;
            end
        end
        e_mem_valid = ga | gb;
        if (ga | gb) begin
            e_mem_addr = gb ? req_b_addr : req_a_addr;
            e_mem_data = gb ? req_b_data : req_a_data;
            e_mem_rw   = gb ? req_b_rw   : req_a_rw;
            e_mem_id   = 4'(tag);
            m_busy[tag] = 1;
            m_src[tag]  = gb;
            m_oid[tag]  = gb ? req_b_id : req_a_id;
        end
        @(posedge clk);
        #1;
        check_regs("cyc");
    endtask

    task automatic idle_inputs();
        req_a_valid = 0; req_b_valid = 0;
        mem_ready_in = 0; mem_stall_in = 0;
    endtask

    task automatic respond(input logic [3:0] tag, input logic [DW-1:0] data);
        bit ga, gb;
        mem_ready_in = 1; mem_id_in = tag; mem_data_in = data;
        cycle(ga, gb);
        mem_ready_in = 0;
    endtask

    bit ga, gb;
    bit seq [4];
    int gb_cnt;

    initial begin
        // Reset
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_regs("reset");
        chk("reset.gnt_a", 64'(gnt_a), 64'd0);
        rst = 1;

        // Single A store
        req_a_valid = 1; req_a_addr = 32'h10; req_a_data = 32'hDEAD; req_a_rw = 1; req_a_id = 4'd3;
        cycle(ga, gb);
        chk("t1.gnt_model", 64'(ga), 64'd1);
        chk("t1.mem_id_lit", 64'(mem_id_out), 64'd0);
        chk("t1.mem_rw_lit", 64'(mem_rw_out), 64'd1);
        chk("t1.outst_lit", 64'(outstanding), 64'd1);
        req_a_valid = 0;
        respond(4'd0, 32'd0);
        chk("t1.rsp_a_lit", 64'(rsp_a_valid), 64'd1);
        chk("t1.rsp_id_lit", 64'(rsp_id), 64'd3);
        chk("t1.outst0_lit", 64'(outstanding), 64'd0);

        // A/B contention, two loads each
        begin
            int na = 2, nb = 2, k = 0;
            req_a_rw = 0; req_a_id = 4'd1; req_b_rw = 0; req_b_id = 4'd2;
            for (int c = 0; c < 8 && (na > 0 || nb > 0); c++) begin
                req_a_valid = (na > 0); req_b_valid = (nb > 0);
                req_a_addr = 32'h100 + 32'(c); req_b_addr = 32'h200 + 32'(c);
                cycle(ga, gb);
                if (k < 4) begin
                    seq[k] = gb;
                    chk("t2.tag_lit", 64'(mem_id_out), 64'(k));
                end
                if (ga | gb) k++;
                if (ga) na--;
                if (gb) nb--;
            end
            idle_inputs();
            chk("t2.order_lit", 64'({seq[0], seq[1], seq[2], seq[3]}), 64'b0101);
            respond(4'd3, 32'hB3);
            chk("t2.rsp_b_lit", 64'({rsp_b_valid, rsp_id}), 64'h12);
            respond(4'd0, 32'hA0);
            chk("t2.rsp_a_lit", 64'({rsp_a_valid, rsp_id}), 64'h11);
            respond(4'd1, 32'hB1);
            respond(4'd2, 32'hA2);
        end

        // Fill every tag from A, then free tag 5 and watch it reallocate
        req_a_valid = 1; req_a_rw = 0;
        for (int i = 0; i < NT; i++) begin
            req_a_id = 4'(i); req_a_addr = 32'h1000 + 32'(i);
            cycle(ga, gb);
        end
        chk("t3.full_lit", 64'(outstanding), 64'd16);
        cycle(ga, gb);
        chk("t3.nogrant_lit", 64'(gnt_a), 64'd0);
        mem_ready_in = 1; mem_id_in = 4'd5; mem_data_in = 32'h55;
        cycle(ga, gb);
        mem_ready_in = 0;
        cycle(ga, gb);
        chk("t3.realloc_lit", 64'({mem_valid_out, mem_id_out}), 64'h15);
        req_a_valid = 0;
        for (int i = 0; i < NT; i++) respond(4'(i), 32'(i));
        chk("t3.drained_lit", 64'(outstanding), 64'd0);

        // Stall blocks grants
        req_a_valid = 1; mem_stall_in = 1; req_a_id = 4'd7;
        for (int i = 0; i < 3; i++) begin
            cycle(ga, gb);
            chk("t4.stall_lit", 64'({gnt_a, mem_valid_out}), 64'd0);
        end
        mem_stall_in = 0;
        cycle(ga, gb);
        chk("t4.resume_lit", 64'(mem_valid_out), 64'd1);
        req_a_valid = 0;
        respond(4'd0, 32'h77);

        // Unknown tag
        respond(4'd9, 32'h99);
        chk("t5.err_lit", 64'({tag_err, rsp_a_valid, rsp_b_valid}), 64'b100);
        cycle(ga, gb);
        chk("t5.sticky_lit", 64'(tag_err), 64'd1);

        // Reset mid-burst with three tags in flight
        req_a_valid = 1;
        for (int i = 0; i < 3; i++) begin
            req_a_id = 4'(i); cycle(ga, gb);
        end
        chk("t6.pre_lit", 64'(outstanding), 64'd3);
        rst = 0;
        #1;
        model_reset();
        check_regs("t6.async");
        chk("t6.gnt_lit", 64'({gnt_a, gnt_b}), 64'd0);
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1;
        cycle(ga, gb);
        chk("t6.outst_lit", 64'(outstanding), 64'd0);
        respond(4'd1, 32'h11);
        chk("t6.stale_lit", 64'({tag_err, rsp_a_valid}), 64'b10);

        // Continuous contention
        gb_cnt = 0;
        req_a_valid = 1; req_b_valid = 1;
        for (int i = 0; i < 6; i++) begin
            cycle(ga, gb);
            gb_cnt += int'(gnt_b === 1'b1);
        end
`ifdef ARB_FIXED_PRIO_EN
        chk("t7.b_starved", 64'(gb_cnt), 64'd0);
`else
        chk("t7.b_share", 64'(gb_cnt), 64'd3);
`endif
        idle_inputs();
        cycle(ga, gb);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dcache_port_arbiter.md
Name: dcache_port_arbiter

Overview:
- Shares the single data-memory port (DCache4KBNew-style interface: addr/data/rw/id/valid in; data/id/ready out; stall out) between two requesters.
- Port A is the load/store queue; port B is a secondary requester (prefetch/debug/DMA).
- Arbitrates requests and renames each requester's 4-bit ld/st id to a free memory tag from a tag table.
- Routes each memory response back to the owning requester with its original id restored.

Parameters:
- NUM_TAGS, 16, memory tags in use; legal range 2..16; tags 0..NUM_TAGS-1; tag width fixed at 4.
- ADDR_W, 32, address width.
- DATA_W, 32, data width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset.
- req_a_valid  in  1  port A request valid; held until granted.
- req_a_addr  in  ADDR_W  port A address.
- req_a_data  in  DATA_W  port A store data.
- req_a_rw  in  1  1 = store, 0 = load.
- req_a_id  in  4  port A ld/st queue id.
- gnt_a  out  1  combinational grant; the request transfers on the cycle req_a_valid && gnt_a.
- req_b_valid, req_b_addr, req_b_data, req_b_rw, req_b_id, gnt_b  same as port A, for port B.
- mem_addr_out  out  ADDR_W  registered request address to memory.
- mem_data_out  out  DATA_W  registered request data to memory.
- mem_rw_out  out  1  registered r/w to memory.
- mem_id_out  out  4  allocated tag.
- mem_valid_out  out  1  request valid to memory.
- mem_data_in  in  DATA_W  response data.
- mem_id_in  in  4  response tag.
- mem_ready_in  in  1  response valid.
- mem_stall_in  in  1  memory cannot accept new requests.
- rsp_a_valid  out  1  registered response valid to port A.
- rsp_b_valid  out  1  registered response valid to port B.
- rsp_data  out  DATA_W  response data, shared by both ports.
- rsp_id  out  4  restored original requester id, shared by both ports.
- outstanding  out  5  count of busy tags.
- tag_err  out  1  sticky error flag.

Behaviour:
- Reset (rst low, asynchronous):
  - All outputs 0; tag table busy bits all 0; outstanding = 0; tag_err = 0.
  - Round-robin pointer = A (A favoured first).
  - Takes effect mid-operation too; responses to in-flight tags are discarded until re-allocation (see unknown-tag rule).
- Tag table, one entry per tag:
  - busy (1 bit), src (0 = A, 1 = B), orig_id (4 bits).
- Grant conditions (combinational):
  - No grant unless mem_stall_in == 0 and at least one free tag exists.
  - The free-tag test uses the busy vector as registered, before this cycle's frees.
- Arbitration:
  - Only one requester valid: it is granted.
  - Both valid: the round-robin pointer selects the winner; after the grant the pointer moves to the loser.
  - The pointer does not move on idle cycles.
- Allocation on a granted request:
  - Allocated tag = lowest-index free tag.
  - Set busy = 1, src, orig_id.
  - Next cycle: mem_valid_out = 1 and mem_* carry that request (1-cycle issue latency).
  - Cycles with no grant: mem_valid_out = 0 next cycle; mem_addr/data/rw/id hold their values.
- Memory stall:
  - mem_stall_in blocks new grants only.
  - A request already presented on mem_valid_out counts as accepted.
- Response (mem_ready_in == 1):
  - Look up entry mem_id_in. If busy: next cycle rsp_x_valid = 1 for x = src, rsp_data = mem_data_in, rsp_id = orig_id; clear busy.
  - Store responses are also returned, with data as supplied by memory (0).
  - Unknown tag (busy == 0): response dropped, no rsp_*_valid, tag_err set to 1 and held until reset.
  - rsp_* not valid: rsp_data and rsp_id hold their values; rsp_a_valid and rsp_b_valid are single-cycle pulses and never both 1.
- Simultaneous free and allocate in one cycle:
  - The freed tag is not eligible for allocation that cycle.
  - outstanding = outstanding + granted - freed (net 0 for one of each).
- Full: outstanding == NUM_TAGS means gnt_a = gnt_b = 0.
- Ordering: responses may return in any order; the block imposes no ordering between ports.

Optional Feature:
- Macro: ARB_FIXED_PRIO_EN.
- Defined: port A always wins when both are valid; the round-robin pointer is removed, so port B can starve.
- Undefined: round-robin arbitration as specified above.

Test Plan:
- Reset, then A store (addr 0x10, data 0xDEAD, id 3) -> gnt_a = 1 same cycle; next cycle mem_valid_out = 1, mem_id_out = 0, rw = 1; memory response tag 0 -> rsp_a_valid, rsp_id = 3, outstanding 1 -> 0.
- A and B loads both valid for 4 cycles, ids 1 and 2 -> grants alternate A, B, A, B; tags 0, 1, 2, 3; responses routed to the correct port with ids 1 and 2.
- Fill all 16 tags from A with no responses -> outstanding = 16, gnt_a = 0; respond tag 5 -> next cycle a grant allocates tag 5.
- mem_stall_in = 1 while A is valid for 3 cycles -> no grant, mem_valid_out = 0; stall drops -> grant on the next cycle.
- Response with tag 9 while tag 9 is free -> no rsp pulse, tag_err = 1 until rst low.
- Assert rst low mid-burst with 3 tags outstanding -> all outputs 0 immediately; outstanding = 0 after release.
- Build with ARB_FIXED_PRIO_EN defined: A and B both valid continuously -> gnt_b never asserts.
